// File: rtl/rcounter_ctrl_if.sv
// Button/time_out inputs and preset/core-control outputs of the countdown controller.
// slave = controller side, master = front-end/core side.
interface rcounter_ctrl_if;
  logic       btn_set;
  logic       btn_field;
  logic       btn_inc;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_clear;
  logic       time_out;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [7:0] preset_ms_10;
  logic       core_en;
  logic       core_rst;
  logic       alarm;
  logic [1:0] edit_field;
  logic [2:0] state;

  modport slave (
    input  btn_set, btn_field, btn_inc, btn_start, btn_stop, btn_clear, time_out,
    output preset_min, preset_sec, preset_ms_10, core_en, core_rst, alarm,
           edit_field, state
  );

  modport master (
    output btn_set, btn_field, btn_inc, btn_start, btn_stop, btn_clear, time_out,
    input  preset_min, preset_sec, preset_ms_10, core_en, core_rst, alarm,
           edit_field, state
  );
endinterface

// File: rtl/rcounter_ctrl.sv
// Countdown timer control FSM: BCD preset editing, run/pause/clear sequencing, timed alarm.
// Latency: button sampled at edge N acts in cycle N+1 (Moore outputs); no backpressure, pulses never stall.
module rcounter_ctrl #(
  parameter int         ALARM_CYCLES = 100,
  parameter logic [7:0] DEF_MIN      = 8'h01,
  parameter logic [7:0] DEF_SEC      = 8'h00,
  parameter logic [7:0] DEF_MS10     = 8'h00
) (
  input  logic           clk_core,
  input  logic           rst,
  rcounter_ctrl_if.slave io
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;

  localparam int            CW         = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    ms_q, ms_d;
  logic [1:0]    field_q, field_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          preset_nz;

  // One-step BCD increment that wraps to 00 once the field's top value is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign preset_nz = |{min_q, sec_q, ms_q};

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    field_d = field_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (io.btn_clear) begin
          state_d = S_IDLE;
        end else if (io.btn_start) begin
          if (preset_nz) state_d = S_RUN;
        end else if (io.btn_set) begin
          state_d = S_SET;
          field_d = 2'd0;
        end
      end
      S_SET: begin
        if (io.btn_clear) begin
          min_d = 8'h00;
          sec_d = 8'h00;
          ms_d  = 8'h00;
        end else if (io.btn_start) begin
          if (preset_nz) state_d = S_RUN;
        end else if (io.btn_set) begin
          state_d = S_IDLE;
        end else if (io.btn_field) begin
          field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
        end else if (io.btn_inc) begin
          case (field_q)
            2'd0:    min_d = bcd_inc(min_q, 8'h59);
            2'd1:    sec_d = bcd_inc(sec_q, 8'h59);
            2'd2:    ms_d  = bcd_inc(ms_q, 8'h99);
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (io.btn_clear) begin
          state_d = S_IDLE;
        end else if (io.time_out) begin
          state_d = S_ALARM;
          cnt_d   = '0;
        end else if (io.btn_stop) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (io.btn_clear)      state_d = S_IDLE;
        else if (io.btn_start) state_d = S_RUN;
      end
      S_ALARM: begin
        if (io.btn_clear || io.btn_stop) state_d = S_IDLE;
        else if (cnt_q == ALARM_LAST)    state_d = S_IDLE;
        else                             cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      min_q   <= DEF_MIN;
      sec_q   <= DEF_SEC;
      ms_q    <= DEF_MS10;
      field_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      field_q <= field_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.preset_min   = min_q;
  assign io.preset_sec   = sec_q;
  assign io.preset_ms_10 = ms_q;
  assign io.core_en      = (state_q == S_RUN);
  assign io.core_rst     = (state_q == S_IDLE) || (state_q == S_SET);
  assign io.alarm        = (state_q == S_ALARM);
  assign io.edit_field   = field_q;
  assign io.state        = state_q;

endmodule

// File: tb/tb_rcounter_ctrl.sv
// Directed bench for rcounter_ctrl with ALARM_CYCLES=4 and default presets (01:00.00).
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_rcounter_ctrl;

  localparam logic [5:0] B_INC   = 6'b000001;
  localparam logic [5:0] B_FIELD = 6'b000010;
  localparam logic [5:0] B_SET   = 6'b000100;
  localparam logic [5:0] B_START = 6'b001000;
  localparam logic [5:0] B_STOP  = 6'b010000;
  localparam logic [5:0] B_CLR   = 6'b100000;

  logic clk_core = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  rcounter_ctrl_if io ();

  rcounter_ctrl #(.ALARM_CYCLES(4)) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .io       (io)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic drive(input logic [5:0] m);
    {io.btn_clear, io.btn_stop, io.btn_start, io.btn_set, io.btn_field, io.btn_inc} = m;
  endtask

  task automatic press(input logic [5:0] m);
    drive(m);
    step();
    drive(6'b0);
  endtask

  initial begin
    rst = 1'b0;
    drive(6'b0);
    io.time_out = 1'b0;
    #12;
    chk("rst_state",    32'(io.state), 32'd0);
    chk("rst_core_en",  32'(io.core_en), 32'd0);
    chk("rst_core_rst", 32'(io.core_rst), 32'd1);
    chk("rst_alarm",    32'(io.alarm), 32'd0);
    chk("rst_min",      32'(io.preset_min), 32'h01);
    chk("rst_sec",      32'(io.preset_sec), 32'h00);
    chk("rst_ms",       32'(io.preset_ms_10), 32'h00);
    chk("rst_field",    32'(io.edit_field), 32'd0);
    step();
    rst = 1'b1;
    step();

    press(B_START);
    chk("start_state",    32'(io.state), 32'd2);
    chk("start_core_en",  32'(io.core_en), 32'd1);
    chk("start_core_rst", 32'(io.core_rst), 32'd0);

    press(B_STOP);
    chk("pause_state",    32'(io.state), 32'd3);
    chk("pause_core_en",  32'(io.core_en), 32'd0);
    chk("pause_core_rst", 32'(io.core_rst), 32'd0);
    io.time_out = 1'b1;
    step();
    io.time_out = 1'b0;
    chk("pause_ign_timeout", 32'(io.state), 32'd3);
    press(B_START);
    chk("resume_state",   32'(io.state), 32'd2);
    chk("resume_core_en", 32'(io.core_en), 32'd1);

    io.time_out = 1'b1;
    press(B_STOP);
    chk("alarm_state", 32'(io.state), 32'd4);
    chk("alarm_c1",    32'(io.alarm), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("alarm_c%0d", i), 32'(io.alarm), 32'd1);
    end
    step();
    chk("alarm_end_state", 32'(io.state), 32'd0);
    chk("alarm_end_alarm", 32'(io.alarm), 32'd0);
    chk("alarm_end_crst",  32'(io.core_rst), 32'd1);
    io.time_out = 1'b0;

    press(B_SET);
    chk("set_state", 32'(io.state), 32'd1);
    chk("set_field", 32'(io.edit_field), 32'd0);
    drive(B_INC);
    repeat (57) step();
    drive(6'b0);
    chk("min_58", 32'(io.preset_min), 32'h58);
    press(B_INC);
    chk("min_59", 32'(io.preset_min), 32'h59);
    press(B_INC);
    chk("min_wrap_00", 32'(io.preset_min), 32'h00);
    press(B_INC);
    chk("min_01", 32'(io.preset_min), 32'h01);
    chk("sec_untouched", 32'(io.preset_sec), 32'h00);
    press(B_FIELD | B_INC);
    chk("field_over_inc_f", 32'(io.edit_field), 32'd1);
    chk("field_over_inc_s", 32'(io.preset_sec), 32'h00);
    press(B_FIELD);
    chk("field_2", 32'(io.edit_field), 32'd2);
    drive(B_INC);
    repeat (10) step();
    drive(6'b0);
    chk("ms_carry_10", 32'(io.preset_ms_10), 32'h10);
    drive(B_INC);
    repeat (89) step();
    drive(6'b0);
    chk("ms_99", 32'(io.preset_ms_10), 32'h99);
    press(B_INC);
    chk("ms_wrap_00",  32'(io.preset_ms_10), 32'h00);
    chk("ms_wrap_min", 32'(io.preset_min), 32'h01);
    chk("ms_wrap_sec", 32'(io.preset_sec), 32'h00);
    press(B_FIELD);
    chk("field_wrap_0", 32'(io.edit_field), 32'd0);
    press(B_SET);
    chk("set_exit", 32'(io.state), 32'd0);
    press(B_INC);
    chk("idle_ign_inc", 32'(io.preset_min), 32'h01);

    press(B_SET);
    press(B_CLR);
    chk("clr_state", 32'(io.state), 32'd1);
    chk("clr_min",   32'(io.preset_min), 32'h00);
    chk("clr_sec",   32'(io.preset_sec), 32'h00);
    chk("clr_ms",    32'(io.preset_ms_10), 32'h00);
    press(B_START);
    chk("set_zero_start", 32'(io.state), 32'd1);
    press(B_SET);
    press(B_START);
    chk("idle_zero_start", 32'(io.state), 32'd0);
    press(B_SET);
    press(B_INC);
    press(B_INC);
    chk("min_02", 32'(io.preset_min), 32'h02);
    press(B_START);
    chk("set_start_run", 32'(io.state), 32'd2);
    press(B_CLR);
    chk("run_clr_state", 32'(io.state), 32'd0);
    chk("run_clr_crst",  32'(io.core_rst), 32'd1);
    chk("run_clr_en",    32'(io.core_en), 32'd0);

    press(B_START);
    chk("run2_state", 32'(io.state), 32'd2);
    step();
    rst = 1'b0;
    #2;
    chk("arst_state", 32'(io.state), 32'd0);
    chk("arst_en",    32'(io.core_en), 32'd0);
    chk("arst_crst",  32'(io.core_rst), 32'd1);
    chk("arst_alarm", 32'(io.alarm), 32'd0);
    chk("arst_min",   32'(io.preset_min), 32'h01);
    chk("arst_sec",   32'(io.preset_sec), 32'h00);
    chk("arst_ms",    32'(io.preset_ms_10), 32'h00);
    #5;
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
